dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit between the core's execute stage and the 32-bit single-port data RAM (1K words, byte-writable, 1-cycle synchronous read).
- Accepts one load or store request at a time and generates the RAM word address, byte enables and lane-replicated store data.
- Captures the RAM read word and returns the load result, aligned and sign- or zero-extended, through a valid/ready response channel.
- Detects misaligned accesses and completes them with an error instead of touching the RAM.

## Interface
Parameters:
- AW, 10, RAM word-address width; byte address bits [AW+1:2] select the word.

Ports:
- clk  in  1  core clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal-size access
- mem_ce  out  1  RAM clock enable
- mem_oce  out  1  RAM output enable; tied 1
- mem_wre  out  1  RAM write enable
- mem_wen  out  4  RAM byte enables; bit i = byte lane i
- mem_ad  out  AW  RAM word address
- mem_din  out  32  RAM write data
- mem_dout  in  32  RAM read data, valid the cycle after the address is clocked

## Operation
- States are IDLE, READ and RESP.
- Accept is req_valid && req_ready. req_ready = (state==IDLE).
- Error condition:
  - req_size==3;
  - req_size==1 with addr[0]=1;
  - req_size==2 with addr[1:0]!=0.
- RAM drive is combinational from the request during an accepted, non-error cycle:
  - mem_ce=1, mem_ad=req_addr[AW+1:2], mem_wre=req_we.
- mem_wen is driven only for stores and is 0000 for loads:
  - byte: 0001 << addr[1:0];
  - half: 0011 when addr[1]=0, 1100 when addr[1]=1;
  - word: 1111.
- mem_din lane replication:
  - byte: {4{wdata[7:0]}};
  - half: {2{wdata[15:0]}};
  - word: wdata.
- In all other cycles, mem_ce=0, mem_wre=0, mem_wen=0000. mem_ad and mem_din are don't-care but held at 0.
- Address bits [31:AW+2] are ignored, so addresses wrap modulo 4·2^AW bytes.
- Transitions from IDLE on accept:
  - error: go to RESP with rsp_err=1 and rdata=0; RAM is not accessed.
  - store: go to RESP with err=0 and rdata=0.
  - load: go to READ; latch addr[1:0], size and unsigned.
- READ always lasts exactly one cycle. At its end, the extracted lane of mem_dout is registered into rsp_rdata and the state goes to RESP.
- Load lane extraction:
  - byte: mem_dout[8·a+7:8·a], where a = latched addr[1:0];
  - half: mem_dout[16·addr[1]+15:16·addr[1]];
  - word: all 32 bits;
  - then extend to 32 bits per req_unsigned.
- RESP: rsp_valid=1. rsp_rdata and rsp_err hold stable until rsp_ready. On handshake, go to IDLE and set rsp_valid=0.
- At most one request is outstanding. A new request can be accepted the cycle after the response handshake.

## Timing
- Reset values:
  - state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0;
  - mem_ce=0, mem_wre=0, mem_wen=0000, mem_ad=0, mem_din=0;
  - mem_oce=1, req_ready=1.
- Store accepted in cycle 0: RAM write commits at the cycle-0 edge; rsp_valid=1 from cycle 1.
- Load accepted in cycle 0: address clocked into RAM at the cycle-0 edge; mem_dout valid in cycle 1 (READ); rsp_valid=1 with data from cycle 2.
- Error accepted in cycle 0: rsp_valid=1 from cycle 1; mem_ce stays 0 throughout.
- Minimum request-to-request spacing: store/error = 2 cycles, load = 3 cycles (rsp_ready held high).
- rsp_ready low for N cycles extends RESP by N cycles. While stalled, mem_ce=0 and the response is unchanged.
- Reset asserted in any state:
  - immediate return to IDLE with all outputs at reset values;
  - a RAM write already clocked is not undone;
  - a pending load response is discarded.
- rsp_ready asserted while not in RESP is ignored.

## Test plan
- Store word 0xDEADBEEF @0x10:
  - cycle 0: mem_wen=1111, mem_ad=4, mem_din=0xDEADBEEF;
  - cycle 1: rsp_valid, err=0, rdata=0.
  - Then load word @0x10: rsp_rdata=0xDEADBEEF in cycle 2.
- Store byte 0x80 @0x13: mem_wen=1000, mem_din=0x80808080.
  - Signed byte load @0x13 returns 0xFFFFFF80.
  - Unsigned byte load @0x13 returns 0x00000080.
  - Word load @0x10 returns 0x80ADBEEF.
- Store half 0x8001 @0x22: mem_wen=1100, mem_din=0x80018001.
  - Signed half load @0x22 returns 0xFFFF8001.
  - Unsigned half load @0x22 returns 0x00008001.
- Misaligned requests, each giving rsp_err=1, rdata=0 in cycle 1, with mem_ce never asserted:
  - word load @0x02;
  - half store @0x01;
  - size=3.
- Back-pressure: after a load, hold rsp_ready=0 for 3 cycles. Require rsp_valid and rsp_rdata stable, req_ready=0 and mem_ce=0 throughout; a request offered meanwhile is not accepted until after the handshake.
- Reset mid-load: deassert reset_n during READ. Require rsp_valid=0 immediately, and req_ready=1 after release. A following store @0x3FFC with addr bit 12 set gives mem_ad=0x3FF (wrap).

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit between the execute stage and a 1-cycle synchronous, byte-writable data RAM.
// One request in flight; loads are lane-extracted and extended, misaligned accesses return an error.
module dmem_lsu #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          mem_ce,
  output logic          mem_oce,
  output logic          mem_wre,
  output logic [3:0]    mem_wen,
  output logic [AW-1:0] mem_ad,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  lat_addr;
  logic [1:0]  lat_size;
  logic        lat_unsigned;

  logic        accept_c;
  logic        err_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_data_c;
  logic        unused_addr_c;

  // Upper address bits fall outside the RAM and wrap.
  assign unused_addr_c = ^req_addr[31:AW+2];

  assign req_ready = (state == IDLE);
  assign mem_oce   = 1'b1;
  assign accept_c  = req_valid && req_ready && reset_n;

  always_comb begin
    err_c = 1'b0;
    unique case (req_size)
      2'd1:    err_c = req_addr[0];
      2'd2:    err_c = (req_addr[1:0] != 2'b00);
      2'd3:    err_c = 1'b1;
      default: err_c = 1'b0;
    endcase
  end

  // RAM strobes are driven straight from the request in the accept cycle.
  always_comb begin
    mem_ce  = 1'b0;
    mem_wre = 1'b0;
    mem_wen = 4'b0000;
    mem_ad  = '0;
    mem_din = 32'h0;
    if (accept_c && !err_c) begin
      mem_ce  = 1'b1;
      mem_wre = req_we;
      mem_ad  = req_addr[AW+1:2];
      if (req_we) begin
        unique case (req_size)
          2'd0: begin
            mem_wen = 4'b0001 << req_addr[1:0];
            mem_din = {4{req_wdata[7:0]}};
          end
          2'd1: begin
            mem_wen = req_addr[1] ? 4'b1100 : 4'b0011;
            mem_din = {2{req_wdata[15:0]}};
          end
          2'd2: begin
            mem_wen = 4'b1111;
            mem_din = req_wdata;
          end
          default: begin
            mem_wen = 4'b0000;
            mem_din = 32'h0;
          end
        endcase
      end
    end
  end

  // Pick the addressed lane of the read word and extend it.
  always_comb begin
    byte_c      = 8'h00;
    half_c      = 16'h0000;
    load_data_c = 32'h0;
    unique case (lat_addr)
      2'd0: byte_c = mem_dout[7:0];
      2'd1: byte_c = mem_dout[15:8];
      2'd2: byte_c = mem_dout[23:16];
      2'd3: byte_c = mem_dout[31:24];
      default: byte_c = 8'h00;
    endcase
    half_c = lat_addr[1] ? mem_dout[31:16] : mem_dout[15:0];
    unique case (lat_size)
      2'd0: load_data_c = lat_unsigned ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'd1: load_data_c = lat_unsigned ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
      2'd2: load_data_c = mem_dout;
      default: load_data_c = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= 32'h0;
      lat_addr     <= 2'b00;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept_c) begin
            if (err_c || req_we) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= err_c;
              rsp_rdata <= 32'h0;
            end else begin
              state        <= READ;
              lat_addr     <= req_addr[1:0];
              lat_size     <= req_size;
              lat_unsigned <= req_unsigned;
            end
          end
        end
        READ: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= load_data_c;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural 1K-word byte-writable RAM.
module tb_dmem_lsu;

  localparam int unsigned AW = 10;

  logic          clk;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_ce;
  logic          mem_oce;
  logic          mem_wre;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_ad;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  logic [31:0]   ram [0:1023];
  int            total;
  int            bad;

  dmem_lsu #(.AW(AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_ce       (mem_ce),
    .mem_oce      (mem_oce),
    .mem_wre      (mem_wre),
    .mem_wen      (mem_wen),
    .mem_ad       (mem_ad),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read word appears the cycle after the address is clocked.
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_wre) begin
        for (int l = 0; l < 4; l++)
          if (mem_wen[l]) ram[mem_ad][8*l +: 8] <= mem_din[8*l +: 8];
      end
      mem_dout <= ram[mem_ad];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request at the negedge, check the RAM strobes, let the edge accept it.
  task automatic send(input string tag, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic ce, input logic [3:0] wen, input logic [31:0] ad,
                      input logic [31:0] din);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".ce"}, 32'(mem_ce), 32'(ce));
    chk({tag, ".wre"}, 32'(mem_wre), 32'(ce & we));
    chk({tag, ".wen"}, 32'(mem_wen), 32'(wen));
    if (ce) begin
      chk({tag, ".ad"}, 32'(mem_ad), ad);
      if (we) chk({tag, ".din"}, mem_din, din);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for the response, check latency and payload, then handshake.
  task automatic get_rsp(input string tag, input logic [31:0] rdata, input logic err,
                         input int lat);
    int n;
    n = 1;
    while (!rsp_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    chk({tag, ".rdata"}, rsp_rdata, rdata);
    chk({tag, ".err"}, 32'(rsp_err), 32'(err));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, ".done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    mem_dout = 32'h0;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    #2;
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.mem_ce", 32'(mem_ce), 32'd0);
    chk("rst.mem_wre", 32'(mem_wre), 32'd0);
    chk("rst.mem_wen", 32'(mem_wen), 32'd0);
    chk("rst.mem_ad", 32'(mem_ad), 32'd0);
    chk("rst.mem_din", mem_din, 32'h0);
    chk("rst.mem_oce", 32'(mem_oce), 32'd1);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Word store then load
    send("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 4'b1111, 32'h4, 32'hDEADBEEF);
    get_rsp("sw10", 32'h0, 1'b0, 1);
    send("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 4'b0000, 32'h4, 32'h0);
    get_rsp("lw10", 32'hDEADBEEF, 1'b0, 2);

    // Byte store and byte/word loads
    send("sb13", 1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, 1'b1, 4'b1000, 32'h4, 32'h80808080);
    get_rsp("sb13", 32'h0, 1'b0, 1);
    send("lb13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1, 4'b0000, 32'h4, 32'h0);
    get_rsp("lb13", 32'hFFFFFF80, 1'b0, 2);
    send("lbu13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, 4'b0000, 32'h4, 32'h0);
    get_rsp("lbu13", 32'h00000080, 1'b0, 2);
    send("lw10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 4'b0000, 32'h4, 32'h0);
    get_rsp("lw10b", 32'h80ADBEEF, 1'b0, 2);
    send("lbu11", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b1, 4'b0000, 32'h4, 32'h0);
    get_rsp("lbu11", 32'h000000BE, 1'b0, 2);
    send("lb12", 1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 1'b1, 4'b0000, 32'h4, 32'h0);
    get_rsp("lb12", 32'hFFFFFFAD, 1'b0, 2);
    send("lh10", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b1, 4'b0000, 32'h4, 32'h0);
    get_rsp("lh10", 32'hFFFFBEEF, 1'b0, 2);

    // Half store and loads
    send("sh22", 1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, 1'b1, 4'b1100, 32'h8, 32'h80018001);
    get_rsp("sh22", 32'h0, 1'b0, 1);
    send("lh22", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b1, 4'b0000, 32'h8, 32'h0);
    get_rsp("lh22", 32'hFFFF8001, 1'b0, 2);
    send("lhu22", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b1, 4'b0000, 32'h8, 32'h0);
    get_rsp("lhu22", 32'h00008001, 1'b0, 2);

    // Misaligned / illegal: no RAM access, error in cycle 1
    send("lw02", 1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    chk("lw02.ce1", 32'(mem_ce), 32'd0);
    get_rsp("lw02", 32'h0, 1'b1, 1);
    send("sh01", 1'b1, 2'd1, 1'b0, 32'h01, 32'h0000FFFF, 1'b0, 4'b0000, 32'h0, 32'h0);
    chk("sh01.ce1", 32'(mem_ce), 32'd0);
    get_rsp("sh01", 32'h0, 1'b1, 1);
    send("sz3", 1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    get_rsp("sz3", 32'h0, 1'b1, 1);
    send("lw00", 1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    get_rsp("lw00", 32'h0, 1'b0, 2);

    // Back-pressure with a competing request offered during the stall
    send("bp", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 4'b0000, 32'h4, 32'h0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
      #1;
      chk("bp.valid", 32'(rsp_valid), 32'd1);
      chk("bp.rdata", rsp_rdata, 32'h80ADBEEF);
      chk("bp.ready", 32'(req_ready), 32'd0);
      chk("bp.ce", 32'(mem_ce), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp.hs_ce", 32'(mem_ce), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("bp.after_valid", 32'(rsp_valid), 32'd0);
    send("bp.sw40", 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, 1'b1, 4'b1111, 32'h10, 32'hCAFEF00D);
    get_rsp("bp.sw40", 32'h0, 1'b0, 1);

    // Reset during READ discards the load
    send("rl", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 4'b0000, 32'h4, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("rl.valid", 32'(rsp_valid), 32'd0);
    chk("rl.ce", 32'(mem_ce), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rl.ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("rl.no_rsp", 32'(rsp_valid), 32'd0);

    // Address wrap: bits above the RAM range are ignored
    send("swwrap", 1'b1, 2'd2, 1'b0, 32'h00003FFC, 32'h12345678, 1'b1, 4'b1111, 32'h3FF, 32'h12345678);
    get_rsp("swwrap", 32'h0, 1'b0, 1);
    send("lwwrap", 1'b0, 2'd2, 1'b0, 32'h00000FFC, 32'h0, 1'b1, 4'b0000, 32'h3FF, 32'h0);
    get_rsp("lwwrap", 32'h12345678, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
